// File: rtl/quant_pack.sv
`default_nettype none
// ============================================================================
//  Module   : quant_pack
//  Purpose  : Requantizes post-ReLU partial sums to bw-bit activations and
//             packs col of them into one output word with an SRAM address.
//             Supports a flush pulse that emits a partially filled word.
//  Revision : 1.0  initial release
// ============================================================================
module quant_pack #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int addr_bw = 11
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [psum_bw-1:0] psum_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                shift,
   input  logic                      flush,
   input  logic                      addr_clr,
   output logic [col*bw-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [addr_bw-1:0]        out_addr
);

   // Lane counter needs at least one bit even for a single-lane configuration.
   localparam int LANE_W = (col > 1) ? $clog2(col) : 1;
   localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(col - 1);
   localparam logic [psum_bw-1:0] QMAX      = psum_bw'((64'd1 << bw) - 64'd1);

   typedef enum logic [0:0] {
      FILL       = 1'b0,
      FLUSH_PEND = 1'b1
   } state_t;

   state_t                  state;
   logic [LANE_W-1:0]       lane_cnt;
   logic [col-1:0][bw-1:0]  pack_buf;

   logic                    out_free;
   logic                    handshake;
   logic                    lane_last;
   logic                    accept;
   logic [bw-1:0]           q;
   logic [col-1:0][bw-1:0]  buf_with;
   logic [LANE_W-1:0]       lane_after;
   logic                    full_load;
   logic                    flush_req;

   // Negative sums clamp to zero; positive ones are shifted then saturated.
   function automatic logic [bw-1:0] quantize(input logic signed [psum_bw-1:0] p,
                                              input logic [3:0] s);
      logic [psum_bw-1:0] mag;
      logic [bw-1:0]      res;
      mag = $unsigned(p) >> s;
      if (p[psum_bw-1])
         res = '0;
      else if (mag > QMAX)
         res = '1;
      else
         res = mag[bw-1:0];
      return res;
   endfunction

   // The single output slot can take a new word when empty or being drained.
   assign out_free  = !out_valid || out_ready;
   assign handshake = out_valid && out_ready;
   assign lane_last = (lane_cnt == LAST_LANE);

   // Stall only when the last lane would complete a word with nowhere to go,
   // or while a deferred flush is waiting for the output slot.
   assign in_ready  = !reset && (state == FILL) && !(lane_last && !out_free);
   assign accept    = in_valid && in_ready;
   assign q         = quantize(psum_in, shift);

   // Pack buffer and lane count as they look with this cycle's input included.
   always_comb begin
      buf_with   = pack_buf;
      lane_after = lane_cnt;
      if (accept) begin
         buf_with[lane_cnt] = q;
         lane_after         = lane_last ? '0 : lane_cnt + LANE_W'(1);
      end
   end

   // A completed word always wins; a flush only matters if lanes remain filled.
   assign full_load = accept && lane_last;
   assign flush_req = flush && (state == FILL) && (lane_after != '0) && !full_load;

   // Control FSM, pack buffer, output register and address counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         lane_cnt  <= '0;
         pack_buf  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
      end else begin
         // Address advances per consumed word; clearing has priority.
         if (addr_clr)
            out_addr <= '0;
         else if (handshake)
            out_addr <= out_addr + addr_bw'(1);

         // A consumed word vacates the slot unless a new load below refills it.
         if (handshake)
            out_valid <= 1'b0;

         case (state)
            FILL: begin
               if (full_load) begin
                  out_data  <= buf_with;
                  out_valid <= 1'b1;
                  pack_buf  <= '0;
                  lane_cnt  <= '0;
               end else if (flush_req) begin
                  if (out_free) begin
                     out_data  <= buf_with;
                     out_valid <= 1'b1;
                     pack_buf  <= '0;
                     lane_cnt  <= '0;
                  end else begin
                     pack_buf  <= buf_with;
                     lane_cnt  <= lane_after;
                     state     <= FLUSH_PEND;
                  end
               end else begin
                  pack_buf <= buf_with;
                  lane_cnt <= lane_after;
               end
            end
            FLUSH_PEND: begin
               if (out_free) begin
                  out_data  <= pack_buf;
                  out_valid <= 1'b1;
                  pack_buf  <= '0;
                  lane_cnt  <= '0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_quant_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quant_pack
//  Purpose  : Self-checking bench for quant_pack. Two instances share the
//             stimulus: default configuration and a 2-bit address variant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quant_pack;

   localparam int BW  = 4;
   localparam int COL = 8;

   logic               clk;
   logic               reset;
   logic signed [15:0] psum_in;
   logic               in_valid;
   logic [3:0]         shift;
   logic               flush;
   logic               addr_clr;
   logic               out_ready;

   logic               in_ready,  in_ready2;
   logic [31:0]        out_data,  out_data2;
   logic               out_valid, out_valid2;
   logic [10:0]        out_addr;
   logic [1:0]         out_addr2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: filled lane values, pending-flush flag, output slot.
   int          lanes[$];
   bit          m_pend;
   bit          m_ov;
   logic [31:0] m_od;
   int          m_addr;
   bit          m_rdy;

   quant_pack #(.bw(4), .psum_bw(16), .col(8), .addr_bw(11)) dut (
      .clk(clk), .reset(reset), .psum_in(psum_in), .in_valid(in_valid),
      .in_ready(in_ready), .shift(shift), .flush(flush), .addr_clr(addr_clr),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr)
   );

   quant_pack #(.bw(4), .psum_bw(16), .col(8), .addr_bw(2)) dut2 (
      .clk(clk), .reset(reset), .psum_in(psum_in), .in_valid(in_valid),
      .in_ready(in_ready2), .shift(shift), .flush(flush), .addr_clr(addr_clr),
      .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
      .out_addr(out_addr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int quant(input int p, input int s);
      int v;
      if (p < 0) return 0;
      v = p / (1 << s);
      return (v > (1 << BW) - 1) ? (1 << BW) - 1 : v;
   endfunction

   function automatic logic [31:0] pack_word();
      logic [31:0] w = 32'h0;
      foreach (lanes[k]) w = w | (32'(lanes[k]) << (BW * k));
      return w;
   endfunction

   function automatic bit model_ready();
      bit free;
      if (reset || m_pend) return 1'b0;
      free = !m_ov || out_ready;
      if (lanes.size() == COL - 1 && !free) return 1'b0;
      return 1'b1;
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_advance();
      bit          free, hs, load;
      logic [31:0] word;
      int          next_addr;
      if (reset) begin
         lanes.delete();
         m_pend = 0; m_ov = 0; m_od = 32'h0; m_addr = 0;
         return;
      end
      free = !m_ov || out_ready;
      hs   = m_ov && out_ready;
      next_addr = addr_clr ? 0 : (hs ? (m_addr + 1) % 2048 : m_addr);
      load = 0;
      word = 32'h0;
      if (!m_pend) begin
         if (in_valid && m_rdy) lanes.push_back(quant(int'(psum_in), int'(shift)));
         if (lanes.size() == COL) begin
            load = 1; word = pack_word(); lanes.delete();
         end else if (flush && lanes.size() > 0) begin
            if (free) begin
               load = 1; word = pack_word(); lanes.delete();
            end else begin
               m_pend = 1;
            end
         end
      end else if (free) begin
         load = 1; word = pack_word(); lanes.delete(); m_pend = 0;
      end
      if (hs) m_ov = 0;
      if (load) begin m_ov = 1; m_od = word; end
      m_addr = next_addr;
   endtask

   // One clock: check in_ready before the edge, outputs just after it.
   task automatic step();
      #1;
      m_rdy = model_ready();
      check("in_ready", 32'(in_ready), 32'(m_rdy));
      check("in_ready_a2", 32'(in_ready2), 32'(m_rdy));
      model_advance();
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data", out_data, m_od);
      check("out_addr", 32'(out_addr), 32'(m_addr % 2048));
      check("out_valid_a2", 32'(out_valid2), 32'(m_ov));
      check("out_data_a2", out_data2, m_od);
      check("out_addr_a2", 32'(out_addr2), 32'(m_addr % 4));
   endtask

   task automatic idle_inputs();
      in_valid = 0; flush = 0; addr_clr = 0; reset = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   task automatic feed(input int p);
      in_valid = 1; psum_in = 16'(p);
      step();
      in_valid = 0;
   endtask

   task automatic do_flush();
      flush = 1;
      step();
      flush = 0;
   endtask

   initial begin
      idle_inputs();
      psum_in = '0; shift = 4'd2; out_ready = 1;
      lanes.delete(); m_pend = 0; m_ov = 0; m_od = 0; m_addr = 0;

      do_reset();
      check("reset_valid", 32'(out_valid), 32'h0);
      check("reset_data", out_data, 32'h0);
      check("reset_addr", 32'(out_addr), 32'h0);

      // Eight evenly spaced sums form one full word.
      for (int i = 0; i < 8; i++) feed(4 * i);
      check("full_word_data", out_data, 32'h7654_3210);
      check("full_word_addr", 32'(out_addr), 32'h0);
      check("full_word_valid", 32'(out_valid), 32'h1);
      step();
      check("full_word_drop", 32'(out_valid), 32'h0);

      // Clamp, saturate, truncate, then flush a partial word.
      do_reset();
      feed(-5); feed(100); feed(60); feed(3);
      do_flush();
      check("sat_flush_data", out_data, 32'h0000_0FF0);
      check("sat_flush_valid", 32'(out_valid), 32'h1);

      // Partial flush then a flush with nothing buffered.
      do_reset();
      feed(4); feed(8); feed(12);
      do_flush();
      check("partial_data", out_data, 32'h0000_0321);
      do_flush();
      check("empty_flush", 32'(out_valid), 32'h0);
      step();
      check("empty_flush_idle", 32'(out_valid), 32'h0);

      // Backpressure: the 16th input stalls until the first word is taken.
      do_reset();
      out_ready = 0;
      for (int i = 0; i < 15; i++) feed(4 * i);
      in_valid = 1; psum_in = 16'(60);
      #1 check("bp_stall_ready", 32'(in_ready), 32'h0);
      step();
      check("bp_hold_data", out_data, 32'h7654_3210);
      out_ready = 1;
      step();
      in_valid = 0;
      check("bp_word2_valid", 32'(out_valid), 32'h1);
      check("bp_word2_data", out_data, 32'hFEDC_BA98);
      check("bp_word2_addr", 32'(out_addr), 32'h1);
      step();

      // Narrow address wraps 0,1,2,3,0 across five words.
      do_reset();
      for (int w = 0; w < 5; w++) begin
         for (int i = 0; i < 8; i++) feed(i);
         check("wrap_addr_seq", 32'(out_addr2), 32'(w % 4));
      end
      step();
      do_reset();
      for (int w = 0; w < 2; w++) for (int i = 0; i < 8; i++) feed(i);
      addr_clr = 1;
      step();
      addr_clr = 0;
      for (int i = 0; i < 8; i++) feed(i);
      check("addr_clr_next", 32'(out_addr2), 32'h0);

      // Reset mid-word discards the partial word.
      do_reset();
      for (int i = 0; i < 5; i++) feed(40);
      do_reset();
      check("mid_reset_valid", 32'(out_valid), 32'h0);
      for (int i = 0; i < 8; i++) feed(4 * (7 - i));
      check("mid_reset_data", out_data, 32'h0123_4567);
      check("mid_reset_addr", 32'(out_addr), 32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         psum_in   = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                 : 16'($signed($urandom_range(0, 240)) - 40);
         shift     = 4'($urandom_range(0, 15) < 10 ? $urandom_range(0, 4) : $urandom_range(0, 15));
         flush     = ($urandom_range(0, 9) == 0);
         addr_clr  = ($urandom_range(0, 49) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         reset     = ($urandom_range(0, 199) == 0);
         step();
      end
      idle_inputs();
      out_ready = 1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
